// File: rtl/multicycle_control.sv
// Multicycle control FSM for a small LEGv8-style core.
// In: clk, reset, instruction, zero, mem_ready. Out: datapath strobes, ALUop, error, state.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  ALUop,
  output logic        ALUSrc,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        error,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    ERROR     = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_ORR,
    C_LDUR, C_STUR, C_CBZ, C_B,
    C_MOVK, C_ILL
  } cls_t;

  state_t      st_q;
  state_t      st_d;
  logic [31:0] ir_q;
  cls_t        cls;
  logic [3:0]  alu_cls;
  logic        is_mem;
  logic        is_br;
  logic        is_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= FETCH;
      ir_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == FETCH && mem_ready)
        ir_q <= instruction;
    end
  end

  // Earlier arms win: B, CBZ, MOVK, then the 11-bit opcodes.
  always_comb begin
    cls = C_ILL;
    case (1'b1)
      ir_q[31:26] == 6'b000101:      cls = C_B;
      ir_q[31:24] == 8'b10110100:    cls = C_CBZ;
      ir_q[31:23] == 9'b111100101:   cls = C_MOVK;
      ir_q[31:21] == 11'b10001011000: cls = C_ADD;
      ir_q[31:21] == 11'b11001011000: cls = C_SUB;
      ir_q[31:21] == 11'b10001010000: cls = C_AND;
      ir_q[31:21] == 11'b10101010000: cls = C_ORR;
      ir_q[31:21] == 11'b11111000010: cls = C_LDUR;
      ir_q[31:21] == 11'b11111000000: cls = C_STUR;
      default:                        cls = C_ILL;
    endcase
  end

  always_comb begin
    alu_cls = 4'd0;
    case (cls)
      C_AND:  alu_cls = 4'd1;
      C_ORR:  alu_cls = 4'd2;
      C_ADD:  alu_cls = 4'd6;
      C_SUB:  alu_cls = 4'd7;
      C_LDUR: alu_cls = 4'd6;
      C_STUR: alu_cls = 4'd6;
      C_CBZ:  alu_cls = 4'd5;
      C_MOVK: alu_cls = 4'd8;
      default: alu_cls = 4'd0;
    endcase
  end

  assign is_mem = (cls == C_LDUR) || (cls == C_STUR);
  assign is_br  = (cls == C_CBZ) || (cls == C_B);
  assign is_r   = (cls == C_ADD) || (cls == C_SUB) ||
                  (cls == C_AND) || (cls == C_ORR) ||
                  (cls == C_MOVK);

  always_comb begin
    st_d     = st_q;
    ALUop    = 4'd0;
    ALUSrc   = 1'b0;
    Reg2Loc  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    error    = 1'b0;
    case (st_q)
      FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          st_d    = DECODE;
        end
      end
      DECODE: begin
        Reg2Loc = (cls == C_STUR) || (cls == C_CBZ);
        st_d    = (cls == C_ILL) ? ERROR : EXECUTE;
      end
      EXECUTE: begin
        ALUop  = alu_cls;
        ALUSrc = is_mem;
        if (is_br) begin
          PCWrite = 1'b1;
          PCSrc   = (cls == C_B) || zero;
          st_d    = FETCH;
        end else if (is_mem) begin
          st_d = MEM;
        end else if (is_r) begin
          st_d = WRITEBACK;
        end else begin
          st_d = ERROR;
        end
      end
      MEM: begin
        ALUop   = alu_cls;
        ALUSrc  = 1'b1;
        MemRead = (cls == C_LDUR);
        // A store commits only on the completing cycle, so an
        // aborted wait never writes memory.
        if (mem_ready) begin
          if (cls == C_STUR) begin
            MemWrite = 1'b1;
            PCWrite  = 1'b1;
            st_d     = FETCH;
          end else begin
            st_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        ALUop    = alu_cls;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemtoReg = (cls == C_LDUR);
        st_d     = FETCH;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: st_d = FETCH;
    endcase
  end

  assign state = st_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 instruction  input  32  memory read data in FETCH; captured into internal IR on IRWrite.
REQ-005 zero  input  1  ALU zero flag, sampled in EXECUTE only.
REQ-006 mem_ready  input  1  memory handshake: access completes in the cycle it is high.
REQ-007 ALUop  output  4  code to ALU: 1 AND, 2 ORR, 3 NOT, 4 pass A, 5 pass B, 6 ADD, 7 SUB, 8 MOVK, 0 idle.
REQ-008 ALUSrc, Reg2Loc, RegWrite, MemRead, MemWrite, MemtoReg  output  1 each  datapath controls.
REQ-009 IRWrite, PCWrite, PCSrc  output  1 each  IR load, PC update, branch-target select.
REQ-010 error  output  1  sticky illegal-opcode flag.
REQ-011 state  output  3  current FSM state, for debug.

Function
REQ-012 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, ERROR=7; codes 5 and 6 go to FETCH.
REQ-013 FETCH: MemRead=1; hold while mem_ready=0; on mem_ready=1 pulse IRWrite, latch instruction, go to DECODE.
REQ-014 DECODE: one cycle; Reg2Loc=1 for STUR and CBZ, else 0; classify IR[31:21]; illegal -> ERROR, else EXECUTE.
REQ-015 Opcodes (IR[31:21]): ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000; CBZ IR[31:24]=10110100; B IR[31:26]=000101; MOVK IR[31:23]=111100101.
REQ-016 Decode priority SHALL be B, CBZ, MOVK, then 11-bit opcodes.
REQ-017 EXECUTE ALUop: ADD 6, SUB 7, AND 1, ORR 2, LDUR/STUR 6 with ALUSrc=1, CBZ 5, MOVK 8, B 0.
REQ-018 EXECUTE next state: R-type/MOVK -> WRITEBACK; LDUR/STUR -> MEM; CBZ/B -> FETCH with PCWrite=1.
REQ-019 PCSrc=1 only in EXECUTE for B, or CBZ with zero=1; otherwise 0 (sequential PC+4).
REQ-020 MEM: ALUop, ALUSrc held from EXECUTE; MemRead=1 (LDUR) or MemWrite=1 (STUR); hold while mem_ready=0.
REQ-021 MEM on mem_ready=1: LDUR -> WRITEBACK; STUR -> FETCH with PCWrite=1.
REQ-022 WRITEBACK: RegWrite=1, PCWrite=1, one cycle; MemtoReg=1 for LDUR, else 0, ALUop held; -> FETCH.
REQ-023 RegWrite, MemWrite, PCWrite, IRWrite SHALL each be high for exactly one cycle per instruction, or not at all.
REQ-024 Cycles with mem_ready=1 immediately: B/CBZ 3, R-type/MOVK/STUR 4, LDUR 5.
REQ-025 ERROR: all strobes 0, ALUop=0, error=1; remain until reset.
REQ-026 Outputs SHALL be Moore functions of state and latched IR; instruction input changes outside FETCH have no effect.
REQ-027 Unlisted outputs SHALL be 0 in every state.

Reset
REQ-028 reset=1 at any clock edge, including mid-FETCH or MEM wait, SHALL force FETCH, clear IR to 0 and error to 0.
REQ-029 Outputs one cycle after reset: state=0, MemRead=1, all other controls 0, ALUop=0.
REQ-030 reset SHALL take priority over mem_ready and all transitions.

Verification
REQ-031 ADD X1,X2,X3 (0x8B030041), mem_ready=1 -> states 0,1,2,4; ALUop=6 in EXECUTE; RegWrite and PCWrite pulse in cycle 4.
REQ-032 LDUR (0xF8400000), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, MemRead=1; WRITEBACK MemtoReg=1.
REQ-033 CBZ (0xB4000000) with zero=1 -> EXECUTE ALUop=5, PCWrite=1, PCSrc=1; repeat with zero=0 -> PCSrc=0.
REQ-034 MOVK (0xF2800000) -> ALUop=8 in EXECUTE; STUR (0xF8000000) -> MemWrite pulse, RegWrite never asserted.
REQ-035 Instruction 0x00000000 -> ERROR after DECODE, error=1 sticky; reset -> FETCH, error=0.
REQ-036 Reset asserted during MEM wait of STUR -> next cycle FETCH, MemWrite never pulsed.
